// File: rtl/spi_pkg.sv
// Shared SPI master types: controller states and the per-transfer mode latched at start.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // cpha=0 samples on leading toggles, cpha=1 on trailing toggles.
    function automatic logic is_sample_toggle(input logic leading, input logic cpha);
        return leading ^ cpha;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: one-cycle tick every CLK_DIV cycles, reloaded on restart.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic enable,
    output logic tick
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = enable && (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= RELOAD;
        end else if (enable) begin
            cnt <= (cnt == '0) ? RELOAD : cnt - CNT_W'(1);
        end
    end
endmodule

// File: rtl/spi_master_param.sv
// Parameterised SPI master: one word per start, all four modes, selectable slave.
//
// state    | meaning
// ST_IDLE  | waiting for an accepted start; sclk parked at last cpol
// ST_SETUP | cs_n asserted, one half-period before the first sclk toggle
// ST_XFER  | 2*DATA_W sclk toggles, shifting mosi and sampling miso
// ST_HOLD  | one half-period with cs_n still asserted, then done
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int NUM_CS  = 1,
    localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_CS-1:0] cs_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);
    localparam int TOG_W = $clog2(2 * DATA_W);
    localparam logic [TOG_W-1:0] LAST_TOG = TOG_W'(2 * DATA_W - 1);

    spi_state_t        state, state_nxt;
    spi_mode_t         mode;
    logic [DATA_W-1:0] tx_sh, rx_sh;
    logic [TOG_W-1:0]  tog_cnt;
    logic              accept, tick, leading, last_tog, xfer_tick;

    assign accept    = (state == ST_IDLE) && start && (32'(cs_sel) < 32'(NUM_CS));
    assign busy      = (state != ST_IDLE);
    assign leading   = ~tog_cnt[0];
    assign last_tog  = (tog_cnt == LAST_TOG);
    assign xfer_tick = (state == ST_XFER) && tick;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (accept),
        .enable  (busy),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept)              state_nxt = ST_SETUP;
            ST_SETUP: if (tick)                state_nxt = ST_XFER;
            ST_XFER:  if (tick && last_tog)    state_nxt = ST_HOLD;
            ST_HOLD:  if (tick)                state_nxt = ST_IDLE;
            default:                           state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode    <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            cs_n    <= '1;
            done    <= 1'b0;
            rx_data <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            tog_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                mode    <= '{cpol: cpol, cpha: cpha};
                sclk    <= cpol;
                cs_n    <= ~(NUM_CS'(1) << cs_sel);
                tog_cnt <= '0;
                rx_sh   <= '0;
                // cpha=0 must present the MSB before the first (sampling) edge.
                if (!cpha) begin
                    mosi  <= tx_data[DATA_W-1];
                    tx_sh <= tx_data << 1;
                end else begin
                    tx_sh <= tx_data;
                end
            end
            if (xfer_tick) begin
                sclk    <= last_tog ? mode.cpol : ~sclk;
                tog_cnt <= tog_cnt + TOG_W'(1);
                if (is_sample_toggle(leading, mode.cpha)) begin
                    rx_sh <= {rx_sh[DATA_W-2:0], miso};
                end
                if (mode.cpha ? leading : (!leading && !last_tog)) begin
                    mosi  <= tx_sh[DATA_W-1];
                    tx_sh <= tx_sh << 1;
                end
            end
            if ((state == ST_HOLD) && tick) begin
                cs_n    <= '1;
                done    <= 1'b1;
                rx_data <= rx_sh;
            end
        end
    end
endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: timing-arithmetic reference model checked every cycle, plus directed literals.
module tb_spi_master_param;
    localparam int DATA_W  = 8;
    localparam int CLK_DIV = 4;
    localparam int NUM_CS  = 4;
    localparam int PER     = (2 * DATA_W + 2) * CLK_DIV;

    logic clk = 1'b0;
    logic rst_n, start, cpol, cpha, miso, miso_reg, loop_en;
    logic [DATA_W-1:0] tx_data, rx_data;
    logic [1:0] cs_sel;
    logic sclk, mosi, busy, done;
    logic [NUM_CS-1:0] cs_n;

    logic start5;
    logic [2:0] cs_sel5;
    logic sclk5, mosi5, busy5, done5;
    logic [4:0] cs_n5;
    logic [7:0] rx_data5;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign miso = loop_en ? mosi : miso_reg;

    spi_master_param #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .NUM_CS(NUM_CS)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data), .cs_sel(cs_sel),
        .cpol(cpol), .cpha(cpha), .miso(miso), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
        .busy(busy), .done(done), .rx_data(rx_data)
    );

    // A 2-bit select cannot encode index 5, so the out-of-range case uses a 5-select instance.
    spi_master_param #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(5)) u_dut_cs5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .tx_data(tx_data), .cs_sel(cs_sel5),
        .cpol(cpol), .cpha(cpha), .miso(miso_reg), .sclk(sclk5), .mosi(mosi5), .cs_n(cs_n5),
        .busy(busy5), .done(done5), .rx_data(rx_data5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: everything follows from n = cycles elapsed since the accepting edge.
    function automatic int toggles_done(input int n);
        int k = n / CLK_DIV - 1;
        if (k < 0) k = 0;
        if (k > 2 * DATA_W) k = 2 * DATA_W;
        return k;
    endfunction

    function automatic logic is_sample_edge(input int n, input logic pha);
        int j = n / CLK_DIV - 1;
        if ((n % CLK_DIV) != 0 || j < 1 || j > 2 * DATA_W) return 1'b0;
        return ((j % 2) == 1) != pha;
    endfunction

    function automatic logic exp_mosi(input logic [DATA_W-1:0] w, input logic pha, input int k,
                                      input logic prev);
        int b;
        if (!pha) begin
            b = k / 2;
        end else begin
            if (k == 0) return prev;
            b = (k - 1) / 2;
        end
        if (b > DATA_W - 1) b = DATA_W - 1;
        return w[DATA_W-1-b];
    endfunction

    logic m_active = 1'b0, m_cpol = 1'b0, m_cpha = 1'b0, m_sclk = 1'b0, m_mosi = 1'b0, m_done = 1'b0;
    int m_n = 0;
    logic [DATA_W-1:0] m_tx = '0, m_acc = '0, m_rx = '0;
    logic [NUM_CS-1:0] m_cs_n = '1;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active <= 1'b0; m_n <= 0; m_done <= 1'b0; m_rx <= '0; m_acc <= '0;
            m_sclk <= 1'b0; m_mosi <= 1'b0; m_cs_n <= '1; m_cpol <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_active) begin
                m_n <= m_n + 1;
                if (is_sample_edge(m_n + 1, m_cpha)) m_acc <= {m_acc[DATA_W-2:0], miso};
                if (m_n + 1 == PER) begin
                    m_active <= 1'b0; m_done <= 1'b1; m_rx <= m_acc; m_cs_n <= '1;
                end else begin
                    m_sclk <= m_cpol ^ ((toggles_done(m_n + 1) % 2) == 1);
                    m_mosi <= exp_mosi(m_tx, m_cpha, toggles_done(m_n + 1), m_mosi);
                end
            end else if (start && int'(cs_sel) < NUM_CS) begin
                m_active <= 1'b1; m_n <= 0; m_tx <= tx_data; m_acc <= '0;
                m_cpol <= cpol; m_cpha <= cpha; m_sclk <= cpol;
                m_cs_n <= ~(NUM_CS'(1) << cs_sel);
                if (!cpha) m_mosi <= tx_data[DATA_W-1];
            end
        end
    end

    always @(negedge clk) begin
        check("sclk", 32'(sclk), 32'(m_sclk));
        check("mosi", 32'(mosi), 32'(m_mosi));
        check("cs_n", 32'(cs_n), 32'(m_cs_n));
        check("busy", 32'(busy), 32'(m_active));
        check("done", 32'(done), 32'(m_done));
        check("rx_data", 32'(rx_data), 32'(m_rx));
    end

    task automatic wait_done(input int t0, output int lat);
        logic found = 1'b0;
        lat = -1;
        for (int i = 0; i < 2 * PER; i++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - t0;
                found = 1'b1;
                break;
            end
        end
        check("done within bound", 32'(found), 32'd1);
    endtask

    task automatic run_xfer(input logic [7:0] tx, input logic [1:0] sel, input logic pol,
                            input logic pha, output int lat, output int rises,
                            output logic [7:0] sbits, output logic [3:0] cs_low);
        int t0;
        logic prev, found;
        @(negedge clk);
        tx_data = tx; cs_sel = sel; cpol = pol; cpha = pha; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc; prev = sclk; rises = 0; sbits = '0; cs_low = '0; lat = -1; found = 1'b0;
        for (int i = 0; i < 2 * PER; i++) begin
            if (busy) cs_low |= ~cs_n;
            @(negedge clk);
            if (!prev && sclk) begin
                rises++;
                sbits = {sbits[6:0], mosi};
            end
            prev = sclk;
            if (done) begin
                lat = cyc - t0;
                found = 1'b1;
                break;
            end
        end
        check("xfer done within bound", 32'(found), 32'd1);
    endtask

    initial begin
        int lat, rises, t0, dn, dcount;
        logic [7:0] sbits;
        logic [3:0] cs_low;
        logic prev_done;
        int t_done[$];

        rst_n = 1'b0; start = 1'b0; tx_data = '0; cs_sel = '0; cpol = 1'b0; cpha = 1'b0;
        miso_reg = 1'b0; loop_en = 1'b0; start5 = 1'b0; cs_sel5 = '0;
        repeat (3) @(negedge clk);
        check("reset sclk", 32'(sclk), 32'd0);
        check("reset mosi", 32'(mosi), 32'd0);
        check("reset cs_n", 32'(cs_n), 32'hF);
        check("reset busy", 32'(busy), 32'd0);
        check("reset rx_data", 32'(rx_data), 32'd0);
        rst_n = 1'b1;

        loop_en = 1'b1;
        run_xfer(8'hA5, 2'd0, 1'b0, 1'b0, lat, rises, sbits, cs_low);
        check("mode0 done latency", 32'(lat), 32'd72);
        check("mode0 sclk rises", 32'(rises), 32'd8);
        check("mode0 mosi bits", 32'(sbits), 32'hA5);
        check("mode0 rx_data", 32'(rx_data), 32'hA5);

        loop_en = 1'b0; miso_reg = 1'b1;
        run_xfer(8'h3C, 2'd2, 1'b1, 1'b1, lat, rises, sbits, cs_low);
        check("mode3 done latency", 32'(lat), 32'd72);
        check("mode3 mosi bits", 32'(sbits), 32'h3C);
        check("mode3 rx_data", 32'(rx_data), 32'hFF);
        check("mode3 sclk idle high", 32'(sclk), 32'd1);
        check("sel2 only cs_n[2] low", 32'(cs_low), 32'h4);
        check("cs_n released at done", 32'(cs_n), 32'hF);

        @(negedge clk);
        cs_sel5 = 3'd5; start5 = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("sel out of range busy", 32'(busy5), 32'd0);
            check("sel out of range cs_n", 32'(cs_n5), 32'h1F);
        end
        cs_sel5 = 3'd4;
        @(negedge clk);
        start5 = 1'b0;
        check("sel NUM_CS-1 busy", 32'(busy5), 32'd1);
        check("sel NUM_CS-1 cs_n", 32'(cs_n5), 32'h0F);

        loop_en = 1'b1;
        @(negedge clk);
        tx_data = 8'h5A; cs_sel = 2'd1; cpol = 1'b0; cpha = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; t0 = cyc;
        repeat (10) @(negedge clk);
        start = 1'b1; tx_data = 8'hFF; cs_sel = 2'd3; cpol = 1'b1; cpha = 1'b1;
        repeat (20) @(negedge clk);
        check("busy start ignored busy", 32'(busy), 32'd1);
        check("busy start ignored cs_n", 32'(cs_n), 32'hD);
        start = 1'b0;
        wait_done(t0, lat);
        check("mid change latency", 32'(lat), 32'd72);
        check("mid change rx_data", 32'(rx_data), 32'h5A);

        loop_en = 1'b0; miso_reg = 1'b1;
        @(negedge clk);
        tx_data = 8'hC3; cs_sel = 2'd3; cpol = 1'b0; cpha = 1'b1; start = 1'b1;
        prev_done = 1'b0;
        for (int i = 0; i < 4 * PER; i++) begin
            @(negedge clk);
            if (done) begin
                t_done.push_back(cyc);
                check("b2b cs_n gap", 32'(cs_n), 32'hF);
                if (t_done.size() == 3) break;
            end else if (prev_done) begin
                check("b2b reselect", 32'(cs_n), 32'h7);
            end
            prev_done = done;
        end
        start = 1'b0;
        check("b2b done count", 32'(t_done.size()), 32'd3);
        if (t_done.size() == 3) begin
            check("b2b period 1", 32'(t_done[1] - t_done[0]), 32'd73);
            check("b2b period 2", 32'(t_done[2] - t_done[1]), 32'd73);
        end

        @(negedge clk);
        tx_data = 8'h96; cs_sel = 2'd0; cpol = 1'b0; cpha = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort cs_n", 32'(cs_n), 32'hF);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort rx_data", 32'(rx_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (PER + 10) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("no done after abort", 32'(dcount), 32'd0);

        dn = 0;
        repeat (3000) begin
            @(negedge clk);
            if (done) dn++;
            start    = ($urandom_range(0, 5) == 0);
            tx_data  = 8'($urandom);
            cs_sel   = 2'($urandom);
            cpol     = 1'($urandom);
            cpha     = 1'($urandom);
            miso_reg = 1'($urandom);
        end
        start = 1'b0;
        check("random transfers completed", 32'(dn >= 20), 32'd1);
        repeat (PER + 5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
